// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the ALU-stage hazard controller.
//   - opcode constants for the instruction classes the controller decodes
//   - the canonical NOP (addi x0,x0,0) driven into the ALU on a bubble
//   - forwarding-select encodings for alu_in1/alu_in2
//   - controller FSM state encoding and the in-flight slot record
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP = 32'h00000013;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_FLUSH     = 2'd2
    } state_e;

    // One in-flight instruction as far as hazards are concerned.
    typedef struct packed {
        logic       we;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/ins_reg_use.sv
// Combinational register-usage decoder for one RV32 instruction.
// Ports:
//   ins        in  32  instruction word
//   uses_rs1   out 1   instruction reads rs1
//   uses_rs2   out 1   instruction reads rs2
//   writes_rd  out 1   instruction writes rd
//   is_load    out 1   instruction is a load
//   rs1/rs2/rd out 5   raw register fields
module ins_reg_use
    import rv32_pkg::*;
(
    input  logic [31:0] ins,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        writes_rd,
    output logic        is_load,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);

    // funct3/funct7 do not affect register usage.
    logic unused_bits;
    assign unused_bits = ^{ins[31:25], ins[14:12]};

    assign rd  = ins[11:7];
    assign rs1 = ins[19:15];
    assign rs2 = ins[24:20];

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (ins[6:0])
            OP_R:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
            OP_I:      begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OP_LOAD:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
            OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_LUI:    writes_rd = 1'b1;
            OP_AUIPC:  writes_rd = 1'b1;
            OP_JAL:    writes_rd = 1'b1;
            OP_JALR:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/alu_hazard_ctrl.sv
// Issue/hazard controller in front of the RV32 ALU stage. Tracks the EX
// (in ALU) and MEM (one stage later) instructions and produces forwarding
// selects, load-use bubbles, memory-wait stalls and post-redirect flushes.
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   id_valid     id_ins holds a real instruction
//   id_ins       instruction offered to the ALU
//   mem_ready    data memory returned the load in the MEM slot
//   redirect     taken jump/branch in EX this cycle
//   issue        id_ins accepted into the ALU this cycle
//   stall        hold PC/fetch/decode registers
//   bubble       drive NOP into the ALU instead of id_ins
//   flush        discard fetch/decode contents
//   fwd_a/fwd_b  alu_in1/alu_in2 source (00 regfile, 01 EX, 10 MEM/WB)
//   err_timeout  sticky: a load waited MEM_TIMEOUT cycles and was dropped
//   state        FSM state for debug (0 RUN, 1 LOAD_WAIT, 2 FLUSH)
// Handshake: id_ins is consumed only in a cycle where issue=1; while stall=1
// the producer must hold id_ins/id_valid unchanged.
module alu_hazard_ctrl
    import rv32_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_ins,
    input  logic        mem_ready,
    input  logic        redirect,
    output logic        issue,
    output logic        stall,
    output logic        bubble,
    output logic        flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        err_timeout,
    output logic [1:0]  state
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    logic       uses_rs1, uses_rs2, writes_rd, is_load;
    logic [4:0] rs1, rs2, rd;

    ins_reg_use u_use (
        .ins       (id_ins),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd),
        .is_load   (is_load),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd)
    );

    state_e               state_q, state_d;
    slot_t                ex_q, ex_d, mem_q, mem_d, id_slot;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                 err_q, err_d;

    logic       issue_c, stall_c, bubble_c, flush_c;
    logic [1:0] fwd_a_c, fwd_b_c;
    logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, load_use;

    assign id_slot = '{we: writes_rd, rd: rd, is_load: is_load};

    // x0 is hard-wired zero, so it never matches.
    assign ex_hit_a  = uses_rs1 && (rs1 != 5'd0) && ex_q.we  && (ex_q.rd  == rs1);
    assign ex_hit_b  = uses_rs2 && (rs2 != 5'd0) && ex_q.we  && (ex_q.rd  == rs2);
    assign mem_hit_a = uses_rs1 && (rs1 != 5'd0) && mem_q.we && (mem_q.rd == rs1);
    assign mem_hit_b = uses_rs2 && (rs2 != 5'd0) && mem_q.we && (mem_q.rd == rs2);

    assign fwd_a_c = ex_hit_a ? FWD_EX : (mem_hit_a ? FWD_MEM : FWD_RF);
    assign fwd_b_c = ex_hit_b ? FWD_EX : (mem_hit_b ? FWD_MEM : FWD_RF);

    // A load result is not available until it leaves MEM, so a consumer
    // directly behind it must wait one cycle. Only a real instruction counts.
    assign load_use = id_valid && ex_q.is_load && (ex_hit_a || ex_hit_b);

    always_comb begin
        state_d     = state_q;
        ex_d        = ex_q;
        mem_d       = mem_q;
        wait_d      = wait_q;
        flush_cnt_d = flush_cnt_q;
        err_d       = err_q;
        issue_c     = 1'b0;
        stall_c     = 1'b0;
        bubble_c    = 1'b0;
        flush_c     = 1'b0;
        case (state_q)
            ST_RUN: begin
                mem_d = ex_q;
                ex_d  = SLOT_EMPTY;
                if (redirect) begin
                    flush_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_W'(FLUSH_CYCLES - 1);
                    end
                end else if (mem_q.is_load && !mem_ready) begin
                    stall_c = 1'b1;
                    mem_d   = mem_q;
                    ex_d    = ex_q;
                    wait_d  = WAIT_W'(1);
                    state_d = ST_LOAD_WAIT;
                end else if (load_use) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end else begin
                    issue_c = id_valid;
                    if (id_valid) ex_d = id_slot;
                end
            end
            ST_LOAD_WAIT: begin
                stall_c = 1'b1;
                if (mem_ready) begin
                    mem_d   = ex_q;
                    ex_d    = SLOT_EMPTY;
                    state_d = ST_RUN;
                end else if (wait_q >= WAIT_W'(MEM_TIMEOUT)) begin
                    // Drop the whole slot, not just we, so RUN does not
                    // re-enter the wait on the same abandoned load.
                    err_d   = 1'b1;
                    mem_d   = SLOT_EMPTY;
                    state_d = ST_RUN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_FLUSH: begin
                flush_c = 1'b1;
                mem_d   = ex_q;
                ex_d    = SLOT_EMPTY;
                if (flush_cnt_q <= FLUSH_W'(1)) state_d = ST_RUN;
                else flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ex_q        <= SLOT_EMPTY;
            mem_q       <= SLOT_EMPTY;
            wait_q      <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wait_q      <= wait_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    // Every output is forced low while reset is held.
    assign issue       = issue_c  & ~rst;
    assign stall       = stall_c  & ~rst;
    assign bubble      = bubble_c & ~rst;
    assign flush       = flush_c  & ~rst;
    assign fwd_a       = rst ? FWD_RF : fwd_a_c;
    assign fwd_b       = rst ? FWD_RF : fwd_b_c;
    assign err_timeout = err_q & ~rst;
    assign state       = rst ? 2'b00 : state_q;

endmodule
